// File: rtl/prbs7_pkg.sv
// PRBS7 (x^7+x^6+1) constants and next-state function, shared by the
// receive-side descrambler and the transmit-side scrambler.
package prbs7_pkg;

    localparam int         LFSR_W       = 7;
    localparam logic [6:0] DEFAULT_SEED = 7'h7F;

    function automatic logic [LFSR_W-1:0] prbs7_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], s[6] ^ s[5]};
    endfunction

endpackage

// File: rtl/prbs7_lfsr.sv
// PRBS7 keystream generator. A load in the same cycle as a step presents
// SEED's key bit and leaves the register one step past SEED.
module prbs7_lfsr
    import prbs7_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic step,
    output logic key
);

    logic [LFSR_W-1:0] lfsr;
    logic [LFSR_W-1:0] cur;

    assign cur = load ? SEED : lfsr;
    assign key = cur[LFSR_W-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lfsr <= SEED;
        else if (load || step)
            lfsr <= step ? prbs7_next(cur) : cur;
    end

endmodule

// File: rtl/prbs7_descrambler.sv
// Serial PRBS7 descrambler: XORs accepted bits with the keystream (or passes
// them through) and packs them LSB-first into WIDTH-bit output words.
module prbs7_descrambler
    import prbs7_pkg::*;
#(
    parameter int                WIDTH = 8,
    parameter logic [LFSR_W-1:0] SEED  = DEFAULT_SEED
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sel,
    input  logic             din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0]    bit_cnt, cnt_cur, cnt_nxt;
    logic [WIDTH-1:0] shift, shift_nxt, word;
    logic             key, accept, bit_v, done;

    prbs7_lfsr #(.SEED(SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (start),
        .step  (accept),
        .key   (key)
    );

    // Only the word-completing bit can stall; it needs the output register free.
    assign din_ready = !(dout_valid && !dout_ready && bit_cnt == LAST);
    assign accept    = din_valid && din_ready;
    assign bit_v     = sel ? (din ^ key) : din;

    always_comb begin
        cnt_cur   = start ? '0 : bit_cnt;
        word      = start ? '0 : shift;
        done      = 1'b0;
        cnt_nxt   = cnt_cur;
        shift_nxt = word;
        if (accept) begin
            word[cnt_cur] = bit_v;
            if (cnt_cur == LAST) begin
                done      = 1'b1;
                cnt_nxt   = '0;
                shift_nxt = '0;
            end else begin
                cnt_nxt   = cnt_cur + 1'b1;
                shift_nxt = word;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt    <= '0;
            shift      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            bit_cnt <= cnt_nxt;
            shift   <= shift_nxt;
            if (done) begin
                dout       <= word;
                dout_valid <= 1'b1;
            end else if (dout_valid && dout_ready) begin
                dout_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_prbs7_descrambler.sv
// Directed and randomized check of prbs7_descrambler against a keystream-sequence model.
module tb_prbs7_descrambler;

    localparam int         W    = 8;
    localparam logic [6:0] SEED = 7'h7F;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0, sel = 1'b0, din = 1'b0, din_valid = 1'b0;
    logic         din_ready;
    logic [W-1:0] dout;
    logic         dout_valid;
    logic         dout_ready = 1'b1;

    int n_chk = 0;
    int n_fail = 0;

    // Keystream as a sequence: k[n] = SEED[6-n] for n<7, else k[n-7]^k[n-6]; period 127.
    logic         ks [0:126];
    int           m_idx, m_cnt;
    logic [W-1:0] m_sh, m_dout;
    logic         m_vld;

    prbs7_descrambler #(.WIDTH(W), .SEED(SEED)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .sel        (sel),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_idx = 0; m_cnt = 0; m_sh = '0; m_dout = '0; m_vld = 1'b0;
    endtask

    // One clock: drive inputs, check din_ready, advance model, check outputs after the edge.
    task automatic cycle(input logic dv, input logic b, input logic s, input logic st);
        logic         exp_rdy, acc, done;
        logic [W-1:0] w;
        din_valid = dv; din = b; sel = s; start = st;
        #1;
        exp_rdy = !(m_vld && !dout_ready && m_cnt == W-1);
        check("din_ready", din_ready, exp_rdy);
        acc  = dv && exp_rdy;
        done = 1'b0;
        w    = '0;
        if (st) begin m_idx = 0; m_cnt = 0; m_sh = '0; end
        if (acc) begin
            m_sh[m_cnt] = s ? (b ^ ks[m_idx % 127]) : b;
            m_idx++;
            m_cnt++;
            if (m_cnt == W) begin done = 1'b1; w = m_sh; m_cnt = 0; m_sh = '0; end
        end
        @(posedge clk);
        if (done) begin m_dout = w; m_vld = 1'b1; end
        else if (m_vld && dout_ready) m_vld = 1'b0;
        #1;
        din_valid = 1'b0; start = 1'b0;
        check("dout_valid", dout_valid, m_vld);
        check("dout", dout, m_dout);
    endtask

    task automatic send_byte(input logic [W-1:0] val, input logic s, input logic st_first);
        for (int i = 0; i < W; i++) cycle(1'b1, val[i], s, st_first && i == 0);
    endtask

    initial begin
        for (int n = 0; n < 127; n++)
            ks[n] = (n < 7) ? SEED[6-n] : (ks[n-7] ^ ks[n-6]);
        model_reset();

        // Reset state
        #1;
        check("rst_dout", dout, 0);
        check("rst_dout_valid", dout_valid, 0);
        check("rst_din_ready", din_ready, 1);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Start pulse, two descrambled zero bytes
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        send_byte(8'h00, 1'b1, 1'b0);
        check("byte0_7F", dout, 8'h7F);
        check("byte0_vld", dout_valid, 1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        check("byte0_one_cycle", dout_valid, 0);
        send_byte(8'h00, 1'b1, 1'b0);
        check("byte1_20", dout, 8'h20);

        // Ones, bypass, and keystream continuity across bypass
        send_byte(8'hFF, 1'b1, 1'b1);
        check("ones_80", dout, 8'h80);
        send_byte(8'hA5, 1'b0, 1'b1);
        check("bypass_A5", dout, 8'hA5);
        send_byte(8'h00, 1'b1, 1'b0);
        check("after_bypass_20", dout, 8'h20);

        // Backpressure on the completing bit
        send_byte(8'h00, 1'b1, 1'b1);
        dout_ready = 1'b0;
        for (int i = 0; i < W-1; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        check("stall_hold_7F", dout, 8'h7F);
        dout_ready = 1'b1;
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        check("stall_release_20", dout, 8'h20);
        check("stall_release_vld", dout_valid, 1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);

        // Mid-word start: separate pulse, then coincident with bit 0
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        send_byte(8'h00, 1'b1, 1'b0);
        check("midword_start_7F", dout, 8'h7F);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
        send_byte(8'h00, 1'b1, 1'b1);
        check("coincident_start_7F", dout, 8'h7F);

        // Randomized traffic including start pulses and consumer stalls
        for (int i = 0; i < 600; i++) begin
            dout_ready = ($urandom_range(0, 3) != 0);
            cycle(($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 39) == 0));
        end
        dout_ready = 1'b1;
        cycle(1'b0, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset while stalled with a pending word
        send_byte(8'h00, 1'b1, 1'b1);
        dout_ready = 1'b0;
        for (int i = 0; i < W; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        check("async_rst_vld", dout_valid, 0);
        check("async_rst_dout", dout, 0);
        check("async_rst_ready", din_ready, 1);
        model_reset();
        @(negedge clk); rst_n = 1'b1; dout_ready = 1'b1;
        @(posedge clk); #1;
        send_byte(8'h00, 1'b1, 1'b0);
        check("post_rst_7F", dout, 8'h7F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
